gray_rx_tracker: RTL and testbench
==================================

Name: gray_rx_tracker

Overview:
- Receive-side counterpart of the binary-to-Gray counter.
- Accepts a stream of Gray-coded WIDTH-bit samples (e.g. a Gray count or position bus), decodes each to binary, and classifies each sample-to-sample transition as hold, +1, -1 or illegal skip.
- Maintains a wide signed-wraparound position accumulator from the steps.
- Sits behind any Gray-coded source in the same clock domain; feeds status/position logic.

Parameters:
- WIDTH, 4, Gray/binary sample width; legal range 2..16.
- POS_WIDTH, 16, position accumulator width; must be >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clear  input  1  synchronous clear of tracking state and pipeline
- in_valid  input  1  gray_in is a new sample this cycle
- gray_in  input  WIDTH  Gray-coded sample
- out_valid  output  1  one-cycle pulse: decoded result of one sample
- bin_out  output  WIDTH  decoded binary of the latest sample; holds between pulses
- step_up  output  1  pulse with out_valid: transition was +1 (mod 2^WIDTH)
- step_down  output  1  pulse with out_valid: transition was -1 (mod 2^WIDTH)
- skip_err  output  1  pulse with out_valid: transition was neither 0 nor +/-1
- err_sticky  output  1  set by any skip_err; cleared only by rst/clear
- position  output  POS_WIDTH  accumulated steps, modulo 2^POS_WIDTH

Behaviour:
- Reset (rst=1, async): all outputs 0; stage registers, prev_bin and primed flag 0.
- Stage 1: on in_valid, register gray_in and set s1_valid; otherwise s1_valid=0.
- Stage 2, when s1_valid:
  - Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i], MSB down to LSB.
  - Register bin_out and pulse out_valid.
- Latency: in_valid at cycle N -> out_valid at N+2. Full throughput: back-to-back samples give back-to-back out_valid. No backpressure.
- Classification uses diff = (bin - prev_bin) mod 2^WIDTH:
  - primed=0 (first sample after rst/clear): no step, no error; set primed=1; position unchanged.
  - diff=0: no step flags, position unchanged.
  - diff=1: step_up, position+1.
  - diff=2^WIDTH-1: step_down, position-1.
  - Any other diff: skip_err, err_sticky<=1, position unchanged.
- prev_bin <= bin on every out_valid, including error samples, so tracking resynchronises on the next sample.
- step_up, step_down and skip_err are mutually exclusive and only ever high together with out_valid.
- Wrap-around:
  - Sample wrap 2^WIDTH-1 -> 0 is a +1 step; 0 -> 2^WIDTH-1 is a -1 step.
  - Position wraps naturally modulo 2^POS_WIDTH (0 - 1 = all ones).
- clear (synchronous, priority over in_valid):
  - Next cycle: s1_valid=0, out_valid=0, primed=0, prev_bin=0, position=0, err_sticky=0. The sample presented with clear is dropped.
  - An in-flight stage-1 sample is also flushed.
  - bin_out retains its last value.
- rst mid-operation: immediate async return to reset state; in-flight samples lost.
- No state machine beyond primed/unprimed. All arithmetic is unsigned modulo its own width.

Test Plan:
- Prime + count up (WIDTH=4): gray 0000,0001,0011,0010 on consecutive cycles -> bin_out 0,1,2,3 at N+2..N+5; first sample has no step, then 3x step_up; position=3; skip_err never high.
- Sample wrap: after priming at gray 1001 (bin 14), send 1000 (15), 0000 (0) -> two step_up pulses; position=2 (not wrapped).
- Down/position wrap: after rst, send gray 0000 then 1000 (bin 15) -> step_down; position=16'hFFFF.
- Illegal skip: prime with 0000, send 0011 (bin 2) -> skip_err pulse, err_sticky=1, position=0. Then send 0110 (bin 4) -> skip_err again. Then 0111 (bin 5) -> step_up, position=1.
- Gaps and holds: samples with idle cycles between them and a repeated gray 0101 -> out_valid exactly 2 cycles after each in_valid, no step on the repeat.
- clear/rst mid-stream:
  - Assert clear together with in_valid while another sample is in stage 1 -> no out_valid for either; position=0, err_sticky=0; next sample re-primes with no step.
  - Async rst pulse between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/gray_rx_tracker.sv
// gray_rx_tracker
// Receive-side tracker for a Gray-coded sample stream. Each sample goes
// through two stages. Stage 1 captures the sample. Stage 2 decodes it to
// binary and compares it with the previous decoded sample. It reports each
// transition as a hold, +1, -1 or illegal skip, and keeps a wraparound
// position accumulator built from the +/-1 steps.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous clear of tracking state and pipeline
//   in_valid   gray_in carries a new sample this cycle
//   gray_in    Gray-coded sample, WIDTH bits
//   out_valid  one-cycle pulse, decoded result of one sample
//   bin_out    decoded binary of the latest sample, holds between pulses
//   step_up    with out_valid: transition was +1 (mod 2^WIDTH)
//   step_down  with out_valid: transition was -1 (mod 2^WIDTH)
//   skip_err   with out_valid: transition was neither 0 nor +/-1
//   err_sticky set by any skip_err, cleared only by rst/clear
//   position   accumulated steps, modulo 2^POS_WIDTH
module gray_rx_tracker #(
  parameter int WIDTH     = 4,
  parameter int POS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     gray_in,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 skip_err,
  output logic                 err_sticky,
  output logic [POS_WIDTH-1:0] position
);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_gray_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     bin_out_q;
  logic                 step_up_q, step_up_d;
  logic                 step_down_q, step_down_d;
  logic                 skip_err_q, skip_err_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [POS_WIDTH-1:0] position_q, position_d;
  logic [WIDTH-1:0]     prev_bin_q;
  logic                 primed_q;
  logic [WIDTH-1:0]     dec_bin;
  logic [WIDTH-1:0]     diff;

  // Stage 1 captures the incoming sample. A clear drops both the sample
  // offered with it and the sample already held here. The Gray register
  // only loads on a valid sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_gray_q  <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_gray_q <= gray_in;
      end
    end
  end

  assign dec_bin = grayToBin(s1_gray_q);
  assign diff    = dec_bin - prev_bin_q;

  // Classify the stage-1 sample against the previous decoded value. The
  // first sample after reset or clear has nothing to compare with, so it
  // only primes the tracker. The subtraction wraps modulo 2^WIDTH, so
  // max->0 counts as +1 and 0->max counts as -1.
  always_comb begin
    step_up_d    = 1'b0;
    step_down_d  = 1'b0;
    skip_err_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    position_d   = position_q;
    if (s1_valid_q && primed_q) begin
      if (diff == WIDTH'(1)) begin
        step_up_d  = 1'b1;
        position_d = position_q + POS_WIDTH'(1);
      end else if (diff == {WIDTH{1'b1}}) begin
        step_down_d = 1'b1;
        position_d  = position_q - POS_WIDTH'(1);
      end else if (diff != '0) begin
        skip_err_d   = 1'b1;
        err_sticky_d = 1'b1;
      end
    end
  end

  // Stage 2 registers the result of one sample. prev_bin follows every
  // sample, including illegal ones, so tracking resynchronises on the next
  // sample. A clear leaves bin_out unchanged so the last value stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      bin_out_q    <= '0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      skip_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      position_q   <= '0;
      prev_bin_q   <= '0;
      primed_q     <= 1'b0;
    end else if (clear) begin
      out_valid_q  <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      skip_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      position_q   <= '0;
      prev_bin_q   <= '0;
      primed_q     <= 1'b0;
    end else begin
      out_valid_q  <= s1_valid_q;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      skip_err_q   <= skip_err_d;
      err_sticky_q <= err_sticky_d;
      position_q   <= position_d;
      if (s1_valid_q) begin
        bin_out_q  <= dec_bin;
        prev_bin_q <= dec_bin;
        primed_q   <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign bin_out    = bin_out_q;
  assign step_up    = step_up_q;
  assign step_down  = step_down_q;
  assign skip_err   = skip_err_q;
  assign err_sticky = err_sticky_q;
  assign position   = position_q;

endmodule

// File: tb/tb_gray_rx_tracker.sv
// tb_gray_rx_tracker
// Directed bench for gray_rx_tracker with WIDTH=4 and POS_WIDTH=16.
// A behavioural model holds a queue of pending samples. Each sample is due
// one edge after capture. The model decodes the sample arithmetically and
// classifies it by modular difference. A compare process checks every DUT
// output against the model on each falling edge. Literal checks at key
// points pin the model itself.
module tb_gray_rx_tracker;

  localparam int W    = 4;
  localparam int PW   = 16;
  localparam int MASK = (1 << W) - 1;
  localparam int PMSK = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  gray_in = '0;
  logic          out_valid;
  logic [W-1:0]  bin_out;
  logic          step_up;
  logic          step_down;
  logic          skip_err;
  logic          err_sticky;
  logic [PW-1:0] position;

  int checks = 0;
  int errors = 0;
  int upCount = 0;

  gray_rx_tracker #(.WIDTH(W), .POS_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .gray_in(gray_in), .out_valid(out_valid), .bin_out(bin_out),
    .step_up(step_up), .step_down(step_down), .skip_err(skip_err),
    .err_sticky(err_sticky), .position(position)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int bin;
  } pend_t;

  pend_t pending[$];
  int    cyc = 0;
  int    mPrev = 0;
  int    mPrimed = 0;
  int    mPos = 0;
  int    mSticky = 0;
  int    expValid = 0;
  int    expBin = 0;
  int    expUp = 0;
  int    expDown = 0;
  int    expSkip = 0;

  // Gray decoding written arithmetically: XOR of the value shifted by every amount.
  function automatic int modelDecode(input int g);
    int b = g;
    for (int k = 1; k < W; k++) b = b ^ (g >> k);
    return b & MASK;
  endfunction

  // Compare one value, counting the check and reporting any difference.
  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Present one input vector for the next rising edge.
  task automatic applyStimulus(input logic v, input logic [W-1:0] g, input logic c);
    @(negedge clk);
    in_valid = v;
    gray_in  = g;
    clear    = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
  endtask

  task automatic sendGray(input logic [W-1:0] g);
    applyStimulus(1'b1, g, 1'b0);
  endtask

  // Behavioural model, advanced at each rising edge and on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending.delete();
      mPrev = 0; mPrimed = 0; mPos = 0; mSticky = 0;
      expValid = 0; expBin = 0; expUp = 0; expDown = 0; expSkip = 0;
    end else begin
      int diff;
      pend_t e;
      cyc++;
      expValid = 0; expUp = 0; expDown = 0; expSkip = 0;
      if (clear) begin
        pending.delete();
        mPrev = 0; mPrimed = 0; mPos = 0; mSticky = 0;
      end else begin
        if (pending.size() > 0 && pending[0].due == cyc) begin
          e = pending.pop_front();
          expValid = 1;
          expBin = e.bin;
          if (mPrimed == 0) begin
            mPrimed = 1;
          end else begin
            diff = (e.bin - mPrev) & MASK;
            if (diff == 1) begin
              expUp = 1; mPos = (mPos + 1) & PMSK;
            end else if (diff == MASK) begin
              expDown = 1; mPos = (mPos - 1) & PMSK;
            end else if (diff != 0) begin
              expSkip = 1; mSticky = 1;
            end
          end
          mPrev = e.bin;
        end
        if (in_valid) pending.push_back('{cyc + 1, modelDecode(int'(gray_in))});
      end
    end
  end

  // Compare all outputs against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("out_valid", int'(out_valid), expValid);
      checkOutput("bin_out", int'(bin_out), expBin);
      checkOutput("step_up", int'(step_up), expUp);
      checkOutput("step_down", int'(step_down), expDown);
      checkOutput("skip_err", int'(skip_err), expSkip);
      checkOutput("err_sticky", int'(err_sticky), mSticky);
      checkOutput("position", int'(position), mPos);
      if (out_valid && step_up) upCount++;
    end
  end

  initial begin
    #1;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset position", int'(position), 0);
    checkOutput("reset bin_out", int'(bin_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Prime, then count up: bin 0,1,2,3.
    $display("[TB] count up");
    upCount = 0;
    sendGray(4'b0000); sendGray(4'b0001); sendGray(4'b0011); sendGray(4'b0010);
    idle(3);
    checkOutput("countup position", int'(position), 3);
    checkOutput("countup bin_out", int'(bin_out), 3);
    checkOutput("countup upCount", upCount, 3);
    checkOutput("countup sticky", int'(err_sticky), 0);

    // Sample wrap 14 -> 15 -> 0.
    $display("[TB] sample wrap");
    applyStimulus(1'b0, '0, 1'b1);
    sendGray(4'b1001); sendGray(4'b1000); sendGray(4'b0000);
    idle(3);
    checkOutput("wrap position", int'(position), 2);
    checkOutput("wrap bin_out", int'(bin_out), 0);

    // Step down from 0 to 15 after reset wraps the position.
    $display("[TB] down wrap");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sendGray(4'b0000); sendGray(4'b1000);
    idle(3);
    checkOutput("down position", int'(position), 16'hFFFF);
    checkOutput("down bin_out", int'(bin_out), 15);

    // Illegal skips, then recovery.
    $display("[TB] skip");
    applyStimulus(1'b0, '0, 1'b1);
    sendGray(4'b0000); sendGray(4'b0011);
    idle(3);
    checkOutput("skip sticky", int'(err_sticky), 1);
    checkOutput("skip position", int'(position), 0);
    sendGray(4'b0110); sendGray(4'b0111);
    idle(3);
    checkOutput("skip recover position", int'(position), 1);
    checkOutput("skip recover bin_out", int'(bin_out), 5);
    checkOutput("skip sticky held", int'(err_sticky), 1);

    // Gaps and a repeated sample.
    $display("[TB] gaps and holds");
    applyStimulus(1'b0, '0, 1'b1);
    sendGray(4'b0101); idle(2); sendGray(4'b0101); idle(1); sendGray(4'b0100);
    idle(3);
    checkOutput("gap position", int'(position), 1);
    checkOutput("gap bin_out", int'(bin_out), 7);

    // Clear with one sample in flight and another offered alongside it.
    $display("[TB] clear mid-stream");
    sendGray(4'b0110);
    idle(3);
    checkOutput("preclear sticky", int'(err_sticky), 1);
    sendGray(4'b0111);
    applyStimulus(1'b1, 4'b0101, 1'b1);
    idle(3);
    checkOutput("clear position", int'(position), 0);
    checkOutput("clear sticky", int'(err_sticky), 0);
    checkOutput("clear bin_out kept", int'(bin_out), 4);
    sendGray(4'b0111); sendGray(4'b0101);
    idle(3);
    checkOutput("reprime position", int'(position), 1);

    // Async reset pulse between clock edges.
    $display("[TB] async reset");
    sendGray(4'b0100);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("arst out_valid", int'(out_valid), 0);
    checkOutput("arst position", int'(position), 0);
    checkOutput("arst bin_out", int'(bin_out), 0);
    checkOutput("arst step_up", int'(step_up), 0);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    idle(3);
    checkOutput("post arst position", int'(position), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
